// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic/shift ops with latency 1,
// iterative shift-add MUL and restoring DIV taking WIDTH cycles.
module alu_exec #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic { IDLE, CALC } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
    OP_MUL = 4'd8, OP_DIV = 4'd9
  } op_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / product low half, or dividend / quotient
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;

  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v, load;

  assign sh_amt = b[SW-1:0];

  // Single-cycle datapath: result, carry and overflow for ops 0..7
  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} - {1'b0, b};
    // Extra bit on the far side of each shift catches the last bit shifted out.
    shl_w  = {1'b0, a} << sh_amt;
    shr_w  = {a, 1'b0} >> sh_amt;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        // Remainder after subtraction is below the divisor, so WIDTH bits suffice.
        it_hi = rem_sh[WIDTH-1:0] - opnd_q;
        it_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        it_hi = rem_sh[WIDTH-1:0];
        it_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // FSM next-state, operand capture and result/flag load
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    fin_res  = sc_res;
    fin_c    = sc_c;
    fin_v    = sc_v;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op <= OP_SHR) begin
            done_d = 1'b1;
            load   = 1'b1;
          end else if (op == OP_MUL || op == OP_DIV) begin
            state_d  = CALC;
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = (op == OP_DIV);
            opnd_d   = (op == OP_DIV) ? b : a;
            lo_d     = (op == OP_DIV) ? a : b;
            hi_d     = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          load    = 1'b1;
          fin_res = it_lo;
          fin_c   = |it_hi;
          fin_v   = 1'b0;
          if (is_div_q && opnd_q == '0) begin
            fin_res = '1;
            fin_c   = 1'b0;
            fin_v   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_en_d  = load;
    result_d = load ? fin_res : result_q;
    c_d      = load ? fin_c : c_q;
    v_d      = load ? fin_v : v_q;
    z_d      = load ? (fin_res == '0) : z_q;
    n_d      = load ? fin_res[WIDTH-1] : n_q;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_en  = wr_en_q;
  assign result = result_q;
  assign z      = z_q;
  assign n      = n_q;
  assign c      = c_q;
  assign v      = v_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, wr_en, z, n, c, v;
  logic [15:0] result;

  int total  = 0;
  int passed = 0;

  // Reference model state
  int          m_rem = 0;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b;
  logic        e_busy = 0, e_done = 0, e_wr = 0, e_z = 0, e_n = 0, e_c = 0, e_v = 0;
  logic [15:0] e_res = 0;

  alu_exec #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .wr_en(wr_en), .result(result),
    .z(z), .n(n), .c(c), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Plain-arithmetic definition of every operation's result and carry/overflow
  task automatic ref_alu(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic cf, output logic vf);
    int unsigned ux = x, uy = y, p, amt;
    int sx = $signed(x), sy = $signed(y), s;
    amt = y % 16;
    cf = 0; vf = 0; r = 0;
    case (o)
      0: begin p = ux + uy; r = p[15:0]; cf = (p > 65535); s = sx + sy; vf = (s > 32767 || s < -32768); end
      1: begin p = ux - uy; r = p[15:0]; cf = (ux < uy); s = sx - sy; vf = (s > 32767 || s < -32768); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = ~x;
      6: begin p = ux * (1 << amt); r = p[15:0]; cf = (amt != 0) && ((p / 65536) % 2 == 1); end
      7: begin p = ux / (1 << amt); r = p[15:0]; cf = (amt != 0) && (((ux >> (amt - 1)) % 2) == 1); end
      8: begin p = ux * uy; r = p[15:0]; cf = (p >= 65536); end
      9: begin
        if (uy == 0) begin r = 16'hFFFF; vf = 1; cf = 0; end
        else begin p = ux / uy; r = p[15:0]; cf = (ux % uy) != 0; end
      end
      default: ;
    endcase
  endtask

  task automatic commit(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic cf, vf;
    ref_alu(o, x, y, r, cf, vf);
    e_res = r; e_c = cf; e_v = vf; e_z = (r == 0); e_n = r[15];
    e_done = 1; e_wr = 1;
  endtask

  // Advance the model by the posedge that will see the given inputs
  task automatic model_step(input logic r_n, input logic s, input logic [3:0] o,
                            input logic [15:0] x, input logic [15:0] y);
    if (!r_n) begin
      m_rem = 0; e_busy = 0; e_done = 0; e_wr = 0;
      e_res = 0; e_z = 0; e_n = 0; e_c = 0; e_v = 0;
    end else begin
      e_done = 0; e_wr = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin e_busy = 0; commit(m_op, m_a, m_b); end
      end else if (s) begin
        if (o < 8) commit(o, x, y);
        else if (o < 10) begin m_rem = 16; e_busy = 1; m_op = o; m_a = x; m_b = y; end
        else e_done = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, let the posedge happen, compare all outputs
  task automatic cycle(input logic r_n, input logic s, input logic [3:0] o,
                       input logic [15:0] x, input logic [15:0] y);
    rst = r_n; start = s; op = o; a = x; b = y;
    model_step(r_n, s, o, x, y);
    @(negedge clk);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("wr_en", wr_en, e_wr);
    chk("result", result, e_res);
    chk("z", z, e_z);
    chk("n", n, e_n);
    chk("c", c, e_c);
    chk("v", v, e_v);
  endtask

  task automatic idle();
    cycle(1, 0, 4'd0, 16'd0, 16'd0);
  endtask

  // Step until done rises, optionally issuing stray starts; lat = -1 if it never does
  task automatic wait_done(input logic stray, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(1, stray, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if (done === 1'b1) begin lat = i; return; end
    end
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    rst = 0; start = 0; op = 0; a = 0; b = 0;

    // Reset
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    idle();
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {z, n, c, v}, 4'b0000);

    // ADD / SUB flags
    cycle(1, 1, 0, 16'hFFFF, 16'h0001);
    chk("add_wrap", {done, wr_en, result, z, c, v}, {2'b11, 16'h0000, 3'b110});
    cycle(1, 1, 0, 16'h7FFF, 16'h0001);
    chk("add_ovf", {result, n, v, c}, {16'h8000, 3'b110});
    cycle(1, 1, 1, 16'd10, 16'd20);
    chk("sub_borrow", {result, c, n}, {16'hFFF6, 2'b11});

    // Back-to-back single-cycle ops
    cycle(1, 1, 2, 16'hF0F0, 16'h0FF0);
    chk("b2b_and", {done, result}, {1'b1, 16'h00F0});
    cycle(1, 1, 3, 16'hF0F0, 16'h0FF0);
    chk("b2b_or", {done, result}, {1'b1, 16'hFFF0});
    cycle(1, 1, 6, 16'h8001, 16'h0001);
    chk("b2b_shl", {done, result, c}, {1'b1, 16'h0002, 1'b1});
    idle();

    // Reserved op: done without write-back, result untouched
    cycle(1, 1, 4'd12, 16'h1234, 16'h5678);
    chk("reserved", {done, wr_en, result}, {2'b10, 16'h0002});
    idle();

    // MUL with stray starts while busy
    cycle(1, 1, 8, 16'd300, 16'd300);
    wait_done(1, lat);
    chk("mul_latency", lat, 16);
    chk("mul_result", {result, c}, {16'h5F90, 1'b1});
    idle();

    // DIV, including divide by zero
    cycle(1, 1, 9, 16'd100, 16'd7);
    wait_done(0, lat);
    chk("div_latency", lat, 16);
    chk("div_result", {result, c, v}, {16'd14, 2'b10});
    cycle(1, 1, 9, 16'd5, 16'd0);
    wait_done(0, lat);
    chk("div0_latency", lat, 16);
    chk("div0_result", {result, c, v}, {16'hFFFF, 2'b01});
    idle();

    // Reset in the middle of a MUL abandons it
    cycle(1, 1, 8, 16'd1234, 16'd77);
    for (int i = 0; i < 7; i++) idle();
    cycle(0, 0, 0, 0, 0);
    chk("abort_busy", {busy, done}, 2'b00);
    for (int i = 0; i < 20; i++) begin
      idle();
      if (done !== 1'b0) chk("abort_no_done", done, 0);
    end
    cycle(1, 1, 0, 16'd2, 16'd3);
    chk("after_abort_add", {done, result}, {1'b1, 16'd5});
    idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic r_n, s;
      logic [3:0] o;
      r_n = ($urandom_range(0, 299) != 0);
      s   = ($urandom_range(0, 9) < 6);
      o   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15));
      cycle(r_n, s, o, rand16(), rand16());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
